// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control sequencer: a Moore FSM that walks each instruction
// through fetch/decode/execute/memory/writeback and counts completed fetches.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    // Memory handshake: a request (MemRead/MemWrite) is held every cycle the
    // FSM sits in FETCH, MEM_RD or MEM_WR; mem_ready=1 in such a cycle means
    // the access completes at the coming edge and the FSM advances. Outside
    // those states mem_ready is don't-care.

    typedef enum logic [3:0] {
        S_RST      = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC     = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_ADDI_EX  = 4'd11,
        S_ADDI_WB  = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t cur_state;
    state_t next_state;
    logic   fetch_done;

    assign fetch_done = (cur_state == S_FETCH) && mem_ready;
    assign state      = cur_state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state   <= S_RST;
            instr_count <= '0;
        end else begin
            cur_state <= next_state;
            if (fetch_done) begin
                instr_count <= instr_count + 1'b1;
            end
        end
    end

    always_comb begin
        next_state = cur_state;
        unique case (cur_state)
            S_RST:    next_state = S_FETCH;
            S_FETCH:  if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MEM_ADDR;
                    OP_RTYPE:     next_state = S_EXEC;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
                    OP_ADDI:      next_state = S_ADDI_EX;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                if (opcode == OP_LW) begin
                    next_state = S_MEM_RD;
                end else if (opcode == OP_SW) begin
                    next_state = S_MEM_WR;
                end else begin
                    next_state = S_FETCH;
                end
            end
            S_MEM_RD:  if (mem_ready) next_state = S_MEM_WB;
            S_MEM_WR:  if (mem_ready) next_state = S_FETCH;
            S_EXEC:    next_state = S_ALU_WB;
            S_ADDI_EX: next_state = S_ADDI_WB;
            S_MEM_WB, S_ALU_WB, S_ADDI_WB, S_BRANCH, S_JUMP:
                next_state = S_FETCH;
            default:   next_state = S_RST;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        illegal_op  = 1'b0;
        unique case (cur_state)
            S_FETCH: begin
                // PC+4 is computed every FETCH cycle, but only committed with the IR
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI:
                        illegal_op = 1'b0;
                    default:
                        illegal_op = 1'b1;
                endcase
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_ALU_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_ADDI_WB: begin
                RegWrite = 1'b1;
            end
            default: begin
                PCWrite = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction state traces and
// control words are predicted from instruction class and random wait counts.
module tb_multicycle_control;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam int SMALL_W = 3;

    logic        clk;
    logic        rst_n;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
    logic [1:0]  ALUSrcB, ALUOp, PCSource;
    logic [3:0]  state;
    logic [31:0] instr_count;
    logic [16:0] s_out;
    logic [3:0]  s_state;
    logic [SMALL_W-1:0] s_count;

    int n_run;
    int n_fail;
    longint exp_cnt;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .illegal_op(illegal_op), .state(state),
        .instr_count(instr_count)
    );

    // Narrow-counter instance exercises the modulo wrap in a few fetches.
    multicycle_control #(.CNT_W(SMALL_W)) dut_small (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(s_out[0]), .PCWriteCond(s_out[1]), .IorD(s_out[2]),
        .MemRead(s_out[3]), .MemWrite(s_out[4]), .IRWrite(s_out[5]),
        .MemtoReg(s_out[6]), .RegDst(s_out[7]), .RegWrite(s_out[8]),
        .ALUSrcA(s_out[9]), .ALUSrcB(s_out[11:10]), .ALUOp(s_out[13:12]),
        .PCSource(s_out[15:14]), .illegal_op(s_out[16]), .state(s_state),
        .instr_count(s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit supported(input logic [5:0] op);
        return op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ ||
               op == OP_J || op == OP_ADDI;
    endfunction

    // Control word per state, straight from the output table:
    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,
    //  RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,illegal_op}
    function automatic logic [16:0] exp_ctrl(input int st, input logic mr, input logic [5:0] op);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ill;
        logic [1:0] srcb, aop, psrc;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ill} = '0;
        srcb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            1:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
            2:  begin srcb = 2'b11; ill = !supported(op); end
            3:  begin srca = 1; srcb = 2'b10; end
            4:  begin mrd = 1; iord = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin mwr = 1; iord = 1; end
            7:  begin srca = 1; aop = 2'b10; end
            8:  begin rw = 1; rdst = 1; end
            9:  begin srca = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
            10: begin pcw = 1; psrc = 2'b10; end
            11: begin srca = 1; srcb = 2'b10; end
            12: begin rw = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, psrc, ill};
    endfunction

    function automatic logic [16:0] obs_ctrl();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};
    endfunction

    // Called at a negedge with the DUT in FETCH; returns at the next FETCH negedge.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input string tag);
        int seq[$];
        bit mrs[$];
        int rw_seen, irw_seen, rw_exp;
        rw_seen = 0; irw_seen = 0;
        for (int k = 0; k < fw; k++) begin seq.push_back(1); mrs.push_back(0); end
        seq.push_back(1); mrs.push_back(1);
        seq.push_back(2); mrs.push_back(1'($urandom_range(0, 1)));
        if (op == OP_LW || op == OP_SW) begin
            seq.push_back(3); mrs.push_back(1'($urandom_range(0, 1)));
            for (int k = 0; k < mw; k++) begin seq.push_back(op == OP_LW ? 4 : 6); mrs.push_back(0); end
            seq.push_back(op == OP_LW ? 4 : 6); mrs.push_back(1);
            if (op == OP_LW) begin seq.push_back(5); mrs.push_back(1'($urandom_range(0, 1))); end
        end else if (op == OP_R) begin
            seq.push_back(7); seq.push_back(8);
            mrs.push_back(1'($urandom_range(0, 1))); mrs.push_back(1'($urandom_range(0, 1)));
        end else if (op == OP_ADDI) begin
            seq.push_back(11); seq.push_back(12);
            mrs.push_back(1'($urandom_range(0, 1))); mrs.push_back(1'($urandom_range(0, 1)));
        end else if (op == OP_BEQ) begin
            seq.push_back(9); mrs.push_back(1'($urandom_range(0, 1)));
        end else if (op == OP_J) begin
            seq.push_back(10); mrs.push_back(1'($urandom_range(0, 1)));
        end
        rw_exp = (op == OP_LW || op == OP_R || op == OP_ADDI) ? 1 : 0;
        opcode = op;
        for (int i = 0; i < seq.size(); i++) begin
            mem_ready = mrs[i];
            #1;
            n_run++;
            if (int'(state) !== seq[i]) begin
                n_fail++;
                $display("FAIL %s state cyc%0d: got %0d want %0d", tag, i, state, seq[i]);
            end
            n_run++;
            if (obs_ctrl() !== exp_ctrl(seq[i], mrs[i], op)) begin
                n_fail++;
                $display("FAIL %s ctrl cyc%0d: got %b want %b", tag, i, obs_ctrl(), exp_ctrl(seq[i], mrs[i], op));
            end
            n_run++;
            if (instr_count !== 32'(exp_cnt) || s_count !== SMALL_W'(exp_cnt)) begin
                n_fail++;
                $display("FAIL %s count cyc%0d: got %0d/%0d want %0d", tag, i, instr_count, s_count, exp_cnt);
            end
            if (RegWrite) rw_seen++;
            if (IRWrite) irw_seen++;
            if (seq[i] == 1 && mrs[i]) exp_cnt++;
            @(negedge clk);
        end
        n_run++;
        if (rw_seen != rw_exp || irw_seen != 1) begin
            n_fail++;
            $display("FAIL %s we_pulses: RegWrite %0d IRWrite %0d want %0d 1", tag, rw_seen, irw_seen, rw_exp);
        end
        n_run++;
        if (state !== 4'd1) begin
            n_fail++;
            $display("FAIL %s next_fetch: got %0d want 1", tag, state);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; opcode = OP_R;
        @(negedge clk); @(negedge clk);
        #1;
        n_run++;
        if (state !== 4'd0 || obs_ctrl() !== 17'd0 || instr_count !== 32'd0 || s_count !== '0) begin
            n_fail++;
            $display("FAIL reset: state %0d ctrl %b cnt %0d want 0 0 0", state, obs_ctrl(), instr_count);
        end
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_run++;
        if (state !== 4'd1 || MemRead !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: state %0d MemRead %b want 1 1", state, MemRead);
        end
    endtask

    task automatic test_reset_mid_lw();
        opcode = OP_LW;
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) @(negedge clk);
        mem_ready = 1'b0;
        #1;
        n_run++;
        if (state !== 4'd4) begin
            n_fail++;
            $display("FAIL mid_lw_reach: state %0d want 4", state);
        end
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        n_run++;
        if (state !== 4'd0 || obs_ctrl() !== 17'd0 || instr_count !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_lw_reset: state %0d ctrl %b cnt %0d want 0 0 0", state, obs_ctrl(), instr_count);
        end
        exp_cnt = 0;
        rst_n = 1'b1;
        @(negedge clk);
        n_run++;
        if (state !== 4'd1 || MemRead !== 1'b1 || MemWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_lw_release: state %0d MemRead %b want 1 1", state, MemRead);
        end
    endtask

    task automatic test_directed();
        run_instr(OP_R, 0, 0, "rtype");
        run_instr(OP_LW, 0, 2, "lw_wait2");
        run_instr(OP_SW, 1, 1, "sw_fetchwait");
        run_instr(OP_BEQ, 0, 0, "beq");
        run_instr(OP_J, 0, 0, "j");
        run_instr(6'b111111, 0, 0, "illegal");
        run_instr(OP_ADDI, 2, 0, "addi");
    endtask

    task automatic test_count_wrap();
        longint start;
        start = exp_cnt;
        while (SMALL_W'(exp_cnt) != '0 || exp_cnt == start) begin
            run_instr(OP_J, 0, 0, "wrap_j");
        end
        #1;
        n_run++;
        if (s_count !== '0 || instr_count !== 32'(exp_cnt)) begin
            n_fail++;
            $display("FAIL count_wrap: small %0d full %0d want 0 %0d", s_count, instr_count, exp_cnt);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [7];
        logic [5:0] op;
        ops[0] = OP_R; ops[1] = OP_LW; ops[2] = OP_SW; ops[3] = OP_BEQ;
        ops[4] = OP_J; ops[5] = OP_ADDI; ops[6] = 6'b000000;
        for (int n = 0; n < 40; n++) begin
            op = ops[$urandom_range(0, 5)];
            if ($urandom_range(0, 6) == 0) begin
                op = 6'($urandom);
            end
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), "random");
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 6; n++) begin
            run_instr(OP_LW, 0, 0, "b2b_lw");
            run_instr(OP_SW, 0, 0, "b2b_sw");
        end
    endtask

    initial begin
        n_run = 0; n_fail = 0; exp_cnt = 0;
        rst_n = 1'b0; opcode = OP_R; mem_ready = 1'b0;
        test_reset();
        test_directed();
        test_reset_mid_lw();
        test_count_wrap();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
